// File: rtl/serial_ctrl_18.sv
// serial_ctrl_18: sequencer that loads, shifts out/in and unloads an 18-bit full-duplex shift register
// Ports: Clk, Reset (sync, active-low); Start/Tx_Data request a frame; Busy/Done/Rx_Data report it;
//   Reg_Clear/Reg_Load/Reg_Shift_En/Reg_D/Reg_Shift_In drive the register, Reg_Shift_Out/Reg_Data_Out observe it;
//   Serial_Out/Serial_In carry data, Serial_Clk/Frame_n are the registered serial clock and frame select.
module serial_ctrl_18 #(
  parameter int WIDTH   = 18,
  parameter int CLK_DIV = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Tx_Data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rx_Data,
  output logic             Reg_Clear,
  output logic             Reg_Load,
  output logic             Reg_Shift_En,
  output logic [WIDTH-1:0] Reg_D,
  output logic             Reg_Shift_In,
  input  logic             Reg_Shift_Out,
  input  logic [WIDTH-1:0] Reg_Data_Out,
  output logic             Serial_Out,
  input  logic             Serial_In,
  output logic             Serial_Clk,
  output logic             Frame_n
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic samp, shift_cyc, last_cyc;
  assign shift_cyc    = state == SHIFT && div_cnt == DIV_LAST;
  assign last_cyc     = shift_cyc && bit_cnt == BIT_LAST;
  assign Busy         = state != IDLE;
  assign Done         = state == DONE;
  assign Reg_Load     = state == LOAD;
  assign Reg_Shift_En = shift_cyc;
  // with CLK_DIV=2 the sample and shift cycles coincide, so the flop would be one bit late
  assign Reg_Shift_In = (CLK_DIV == 2) ? Serial_In : samp;
  assign Reg_Clear    = ~Reset;
  assign Serial_Out   = Reg_Shift_Out;
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        state_nxt = Start ? LOAD : IDLE;
        div_nxt   = Start ? '0 : div_cnt;
        bit_nxt   = Start ? '0 : bit_cnt;
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: begin
        div_nxt   = shift_cyc ? '0 : div_cnt + DW'(1);
        bit_nxt   = shift_cyc ? bit_cnt + BW'(1) : bit_cnt;
        state_nxt = last_cyc ? DONE : SHIFT;
      end
      DONE: state_nxt = IDLE;
    endcase
  end
  // Serial_Clk and Frame_n are computed from next-state values so the flops line up with the state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      samp       <= 1'b0;
      Rx_Data    <= '0;
      Reg_D      <= '0;
      Serial_Clk <= 1'b0;
      Frame_n    <= 1'b1;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      samp       <= (state == SHIFT && div_cnt == DIV_HALF) ? Serial_In : samp;
      Reg_D      <= (state == IDLE && Start) ? Tx_Data : Reg_D;
      Rx_Data    <= last_cyc ? WIDTH'({Reg_Shift_In, Reg_Data_Out} >> 1) : Rx_Data;
      Serial_Clk <= state_nxt == SHIFT && div_nxt >= DIV_HALF;
      Frame_n    <= !(state_nxt == LOAD || state_nxt == SHIFT);
    end
  end
endmodule

// File: tb/tb_serial_ctrl_18.sv
// tb_serial_ctrl_18: checks serial_ctrl_18 (CLK_DIV 4 and 2) against frame timing computed from cycle arithmetic
module tb_serial_ctrl_18;
  logic Clk = 1'b0;
  logic Reset, Start, sel, lb, sin_drv;
  logic [17:0] Tx_Data;
  int tests = 0;
  int fails = 0;
  always #5 Clk = ~Clk;
  logic busy_a, done_a, clr_a, ld_a, sh_a, si_a, sout_a, sin_a, sclk_a, frn_a;
  logic busy_b, done_b, clr_b, ld_b, sh_b, si_b, sout_b, sin_b, sclk_b, frn_b;
  logic [17:0] rx_a, d_a, q_a, rx_b, d_b, q_b;
  assign sin_a = lb ? sout_a : sin_drv;
  assign sin_b = lb ? sout_b : sin_drv;
  serial_ctrl_18 u_dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start & ~sel), .Tx_Data(Tx_Data),
    .Busy(busy_a), .Done(done_a), .Rx_Data(rx_a), .Reg_Clear(clr_a),
    .Reg_Load(ld_a), .Reg_Shift_En(sh_a), .Reg_D(d_a), .Reg_Shift_In(si_a),
    .Reg_Shift_Out(q_a[0]), .Reg_Data_Out(q_a), .Serial_Out(sout_a),
    .Serial_In(sin_a), .Serial_Clk(sclk_a), .Frame_n(frn_a)
  );
  serial_ctrl_18 #(.CLK_DIV(2)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start & sel), .Tx_Data(Tx_Data),
    .Busy(busy_b), .Done(done_b), .Rx_Data(rx_b), .Reg_Clear(clr_b),
    .Reg_Load(ld_b), .Reg_Shift_En(sh_b), .Reg_D(d_b), .Reg_Shift_In(si_b),
    .Reg_Shift_Out(q_b[0]), .Reg_Data_Out(q_b), .Serial_Out(sout_b),
    .Serial_In(sin_b), .Serial_Clk(sclk_b), .Frame_n(frn_b)
  );
  always_ff @(posedge Clk) q_a <= clr_a ? '0 : ld_a ? d_a : sh_a ? {si_a, q_a[17:1]} : q_a;
  always_ff @(posedge Clk) q_b <= clr_b ? '0 : ld_b ? d_b : sh_b ? {si_b, q_b[17:1]} : q_b;
  logic busy, done, clr, ld, sh, sout, sclk, frn;
  logic [17:0] rx, q, rd;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign clr  = sel ? clr_b : clr_a;
  assign ld   = sel ? ld_b : ld_a;
  assign sh   = sel ? sh_b : sh_a;
  assign sout = sel ? sout_b : sout_a;
  assign sclk = sel ? sclk_b : sclk_a;
  assign frn  = sel ? frn_b : frn_a;
  assign rx   = sel ? rx_b : rx_a;
  assign q    = sel ? q_b : q_a;
  assign rd   = sel ? d_b : d_a;
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // One frame (or back-to-back frames when hold=1) accepted at the end of cycle 0; cycle c is sampled after edge c.
  // Expected waveforms come from the frame timing: LOAD at 1, shifts at 1+d*j, DONE at 2+18d, period 3+18d.
  task automatic run(input int d, input logic [17:0] tx, input logic lb_m, input logic [17:0] bits,
                     input logic hold, input int poke, input int rst_at, input int ncyc, input string tag);
    logic [255:0] o_ld, o_sh, o_dn, o_fr, o_sc, o_by, e_ld, e_sh, e_dn, e_fr, e_sc, e_by;
    logic [17:0] so_lo, so_hi, o_rx, o_q;
    int p, n, k;
    p = 3 + 18 * d;
    n = 1 + 18 * d;
    {o_ld, o_sh, o_dn, o_fr, o_sc, o_by} = '0;
    {e_ld, e_sh, e_dn, e_fr, e_sc, e_by} = '0;
    {so_lo, so_hi, o_rx, o_q} = '0;
    sel = d == 2;
    lb = lb_m;
    Tx_Data = tx;
    Start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge Clk);
      #1;
      k = hold ? c % p : c;
      Start = hold || c == poke;
      Reset = c != rst_at;
      sin_drv = (k >= 2 && k <= n) ? bits[(k - 2) / d] : 1'b0;
      #1;
      if (rst_at == 0 || c <= rst_at) begin
        e_ld[c] = k == 1;
        e_sh[c] = k >= 1 + d && k <= n && (k - 1) % d == 0;
        e_dn[c] = k == n + 1;
        e_fr[c] = k >= 1 && k <= n;
        e_sc[c] = k >= 2 && k <= n && (k - 2) % d >= d / 2;
        e_by[c] = k >= 1 && k <= n + 1;
      end
      o_ld[c] = ld;
      o_sh[c] = sh;
      o_dn[c] = done;
      o_fr[c] = ~frn;
      o_sc[c] = sclk;
      o_by[c] = busy;
      if (c < p && k >= 2 && k <= n && (k - 2) % d == 0) so_lo[(k - 2) / d] = sout;
      if (c < p && k >= 2 && k <= n && (k - 2) % d == d - 1) so_hi[(k - 2) / d] = sout;
      if (c == n + 1) begin
        o_rx = rx;
        o_q = q;
      end
      if (c == rst_at) chk({tag, "_clear"}, {255'b0, clr}, 256'd1);
    end
    chk({tag, "_load"}, o_ld, e_ld);
    chk({tag, "_shift"}, o_sh, e_sh);
    chk({tag, "_done"}, o_dn, e_dn);
    chk({tag, "_frame"}, o_fr, e_fr);
    chk({tag, "_sclk"}, o_sc, e_sc);
    chk({tag, "_busy"}, o_by, e_by);
    if (rst_at == 0) begin
      chk({tag, "_sout_lo"}, {238'b0, so_lo}, {238'b0, tx});
      chk({tag, "_sout_hi"}, {238'b0, so_hi}, {238'b0, tx});
      chk({tag, "_rx"}, {238'b0, o_rx}, {238'b0, lb_m ? tx : bits});
      chk({tag, "_reg"}, {238'b0, o_q}, {238'b0, lb_m ? tx : bits});
    end else begin
      chk({tag, "_rx_cleared"}, {238'b0, rx}, 256'd0);
    end
  endtask
  task automatic drain();
    int i;
    i = 0;
    Start = 1'b0;
    do begin
      @(posedge Clk);
      #2;
      i++;
    end while (busy && i < 300);
    chk("drain", {255'b0, busy}, 256'd0);
  endtask
  initial begin
    Reset = 1'b0;
    Start = 1'b1;
    sel = 1'b0;
    lb = 1'b0;
    sin_drv = 1'b0;
    Tx_Data = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #2;
      chk("rst_busy", {255'b0, busy}, 256'd0);
      chk("rst_done", {255'b0, done}, 256'd0);
      chk("rst_frame_n", {255'b0, frn}, 256'd1);
      chk("rst_sclk", {255'b0, sclk}, 256'd0);
      chk("rst_rx", {238'b0, rx}, 256'd0);
      chk("rst_reg_d", {238'b0, rd}, 256'd0);
      chk("rst_clear", {255'b0, clr}, 256'd1);
      chk("rst_load", {255'b0, ld}, 256'd0);
    end
    Reset = 1'b1;
    Start = 1'b0;
    @(posedge Clk);
    #2;
    chk("post_rst_load", {255'b0, ld}, 256'd0);
    chk("post_rst_clear", {255'b0, clr}, 256'd0);
    run(4, 18'h2A5C3, 1'b1, 18'h0, 1'b0, 0, 0, 75, "lb4");
    run(4, 18'h00000, 1'b0, 18'h3FFFF, 1'b0, 0, 0, 75, "const1");
    for (int i = 0; i < 3; i++) run(4, 18'($urandom), 1'b0, 18'($urandom), 1'b0, 0, 0, 75, "rnd4");
    run(4, 18'($urandom), 1'b1, 18'h0, 1'b0, 0, 0, 75, "rnd_lb4");
    run(4, 18'h0F0F0, 1'b1, 18'h0, 1'b0, 30, 0, 80, "poke30");
    run(4, 18'h3C3C3, 1'b1, 18'h0, 1'b1, 0, 0, 160, "hold");
    drain();
    run(4, 18'h15555, 1'b1, 18'h0, 1'b0, 0, 40, 50, "rst40");
    run(4, 18'h12345, 1'b1, 18'h0, 1'b0, 0, 0, 75, "after_rst");
    run(2, 18'h00001, 1'b1, 18'h0, 1'b0, 0, 0, 39, "lb2");
    run(2, 18'($urandom), 1'b0, 18'($urandom), 1'b0, 0, 0, 39, "rnd2");
    run(2, 18'($urandom), 1'b1, 18'h0, 1'b0, 0, 0, 39, "rnd_lb2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
